// File: rtl/cube_pkg.sv
// Shared definitions for the cube line sequencer and its geometry source:
// FSM state encoding, default widths and the frame line count.
package cube_pkg;

  localparam int XY_BITW_DEF  = 16;
  localparam int LINEW_DEF    = 4;
  localparam int COLORW_DEF   = 3;
  localparam int N_LINES_DEF  = 12;
  localparam int GEOM_LAT_DEF = 1;

  // Wide enough for the largest legal geometry latency (7).
  localparam int LAT_CNTW = 3;

  typedef logic [1:0] cube_state_t;

  localparam cube_state_t ST_IDLE  = 2'd0;
  localparam cube_state_t ST_FETCH = 2'd1;
  localparam cube_state_t ST_ISSUE = 2'd2;
  localparam cube_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/seq_lat_counter.sv
// Up-counter with synchronous clear; tc marks the TERM-th enabled cycle
// after a clear.
module seq_lat_counter
  import cube_pkg::*;
#(
  parameter int unsigned TERM = 1
)(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [LAT_CNTW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = enable && (count == LAT_CNTW'(TERM - 1));

endmodule

// File: rtl/cube_line_seq.sv
// Walks the lines of one cube frame: asks the geometry source for each line,
// waits its latency, then hands a registered descriptor to the rasterizer.
module cube_line_seq
  import cube_pkg::*;
#(
  parameter int XY_BITW  = XY_BITW_DEF,
  parameter int LINEW    = LINEW_DEF,
  parameter int COLORW   = COLORW_DEF,
  parameter int N_LINES  = N_LINES_DEF,
  parameter int GEOM_LAT = GEOM_LAT_DEF
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [LINEW-1:0]   geom_line_id,
  input  logic [COLORW-1:0]  geom_color,
  input  logic [XY_BITW-1:0] geom_x0,
  input  logic [XY_BITW-1:0] geom_y0,
  input  logic [XY_BITW-1:0] geom_x1,
  input  logic [XY_BITW-1:0] geom_y1,
  output logic               line_valid,
  input  logic               line_ready,
  output logic [LINEW-1:0]   line_id,
  output logic [COLORW-1:0]  line_color,
  output logic [XY_BITW-1:0] line_x0,
  output logic [XY_BITW-1:0] line_y0,
  output logic [XY_BITW-1:0] line_x1,
  output logic [XY_BITW-1:0] line_y1,
  output logic               busy,
  output logic               done
);

  localparam logic [LINEW-1:0] LAST_ID = LINEW'(N_LINES - 1);

  cube_state_t state;
  logic        lat_tc;
  logic        lat_enable;
  logic        lat_clear;

  // Counter idles at zero outside FETCH so every line starts a fresh wait.
  assign lat_enable = (state == ST_FETCH);
  assign lat_clear  = !lat_enable || lat_tc;

  seq_lat_counter #(
    .TERM (GEOM_LAT)
  ) u_lat (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (lat_clear),
    .enable (lat_enable),
    .tc     (lat_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      geom_line_id <= '0;
      line_id      <= '0;
      line_color   <= '0;
      line_x0      <= '0;
      line_y0      <= '0;
      line_x1      <= '0;
      line_y1      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state        <= ST_FETCH;
            geom_line_id <= '0;
          end
        end
        ST_FETCH: begin
          if (abort) begin
            state        <= ST_IDLE;
            geom_line_id <= '0;
          end else if (lat_tc) begin
            state      <= ST_ISSUE;
            line_id    <= geom_line_id;
            line_color <= geom_color;
            line_x0    <= geom_x0;
            line_y0    <= geom_y0;
            line_x1    <= geom_x1;
            line_y1    <= geom_y1;
          end
        end
        ST_ISSUE: begin
          // Abort wins even on a handshake: the frame is dropped as a whole.
          if (abort) begin
            state        <= ST_IDLE;
            geom_line_id <= '0;
          end else if (line_ready) begin
            if (line_id == LAST_ID) begin
              state <= ST_DONE;
            end else begin
              state        <= ST_FETCH;
              geom_line_id <= geom_line_id + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state        <= ST_IDLE;
          geom_line_id <= '0;
        end
        default: begin
          state        <= ST_IDLE;
          geom_line_id <= '0;
        end
      endcase
    end
  end

  assign line_valid = (state == ST_ISSUE);
  assign busy       = (state == ST_FETCH) || (state == ST_ISSUE);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_cube_line_seq.sv
// Directed bench for cube_line_seq: one default-latency instance and one
// with GEOM_LAT=3 fed by a delayed geometry source.
module tb_cube_line_seq;

  localparam int XW = 16;
  localparam int LW = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic abort = 1'b0;
  logic ready = 1'b1;

  always #5 clk = ~clk;

  logic [LW-1:0] gid_a, gid_b, id_a, id_b, src_id_b, d1_b, d2_b;
  logic [CW-1:0] gcol_a, gcol_b, col_a, col_b;
  logic [XW-1:0] gx0_a, gy0_a, gx1_a, gy1_a, gx0_b, gy0_b, gx1_b, gy1_b;
  logic [XW-1:0] x0_a, y0_a, x1_a, y1_a, x0_b, y0_b, x1_b, y1_b;
  logic          v_a, v_b, busy_a, busy_b, done_a, done_b;

  function automatic logic [XW-1:0] gcoord(input logic [LW-1:0] id, input logic [3:0] k);
    return {k, 8'h5A, id};
  endfunction

  function automatic logic [CW-1:0] gcolor(input logic [LW-1:0] id);
    return id[2:0] ^ 3'b101;
  endfunction

  // Source A answers combinationally; source B lags line_id by two registers.
  assign gcol_a = gcolor(gid_a);
  assign gx0_a  = gcoord(gid_a, 4'd1);
  assign gy0_a  = gcoord(gid_a, 4'd2);
  assign gx1_a  = gcoord(gid_a, 4'd3);
  assign gy1_a  = gcoord(gid_a, 4'd4);

  always @(posedge clk) begin
    d1_b <= gid_b;
    d2_b <= d1_b;
  end
  assign src_id_b = d2_b;
  assign gcol_b = gcolor(src_id_b);
  assign gx0_b  = gcoord(src_id_b, 4'd1);
  assign gy0_b  = gcoord(src_id_b, 4'd2);
  assign gx1_b  = gcoord(src_id_b, 4'd3);
  assign gy1_b  = gcoord(src_id_b, 4'd4);

  cube_line_seq u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
    .geom_line_id(gid_a), .geom_color(gcol_a),
    .geom_x0(gx0_a), .geom_y0(gy0_a), .geom_x1(gx1_a), .geom_y1(gy1_a),
    .line_valid(v_a), .line_ready(ready), .line_id(id_a), .line_color(col_a),
    .line_x0(x0_a), .line_y0(y0_a), .line_x1(x1_a), .line_y1(y1_a),
    .busy(busy_a), .done(done_a)
  );

  cube_line_seq #(.GEOM_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
    .geom_line_id(gid_b), .geom_color(gcol_b),
    .geom_x0(gx0_b), .geom_y0(gy0_b), .geom_x1(gx1_b), .geom_y1(gy1_b),
    .line_valid(v_b), .line_ready(ready), .line_id(id_b), .line_color(col_b),
    .line_x0(x0_b), .line_y0(y0_b), .line_x1(x1_b), .line_y1(y1_b),
    .busy(busy_b), .done(done_b)
  );

  logic          sel = 1'b0;
  logic          mon_valid, mon_busy, mon_done;
  logic [LW-1:0] mon_id;
  logic [70:0]   mon_data;

  assign mon_valid = sel ? v_b : v_a;
  assign mon_busy  = sel ? busy_b : busy_a;
  assign mon_done  = sel ? done_b : done_a;
  assign mon_id    = sel ? id_b : id_a;
  assign mon_data  = sel ? {id_b, col_b, x0_b, y0_b, x1_b, y1_b}
                         : {id_a, col_a, x0_a, y0_a, x1_a, y1_a};

  int n_cmp = 0;
  int n_bad = 0;

  int cyc, busy_cnt, hs_cnt, done_cnt, last_hs, done_cyc, exp_spacing;
  int stall_line = -1;
  int stall_left = 0;
  logic repulse = 1'b0;
  logic held_v;
  logic [70:0] held_data;
  logic [LW-1:0] exp_id;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    cyc = 0; busy_cnt = 0; hs_cnt = 0; done_cnt = 0;
    last_hs = -100; done_cyc = -1; held_v = 1'b0; exp_id = '0;
  endtask

  task automatic observe(input int ncyc);
    logic hs;
    logic [LW-1:0] eid;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      cyc++;
      start_a = repulse && ((mon_valid && mon_id == 4'd2) || mon_done);
      start_b = 1'b0;
      if (stall_left > 0 && mon_valid && int'(mon_id) == stall_line) begin
        ready = 1'b0;
        stall_left--;
      end else begin
        ready = 1'b1;
      end
      if (held_v) begin
        check("hold_valid", 128'(mon_valid), 128'(1'b1));
        check("hold_data", 128'(mon_data), 128'(held_data));
      end
      hs = mon_valid && ready;
      if (mon_valid) begin
        eid = mon_id;
        check("id_order", 128'(mon_id), 128'(exp_id));
        check("line_data", 128'(mon_data),
              128'({eid, gcolor(eid), gcoord(eid, 4'd1), gcoord(eid, 4'd2),
                    gcoord(eid, 4'd3), gcoord(eid, 4'd4)}));
      end
      if (hs) begin
        if (exp_spacing > 0 && hs_cnt > 0)
          check("hs_spacing", 128'(cyc - last_hs), 128'(exp_spacing));
        $display("line %0d accepted at cycle %0d", mon_id, cyc);
        hs_cnt++;
        exp_id = exp_id + 1'b1;
        last_hs = cyc;
        held_v = 1'b0;
      end else if (mon_valid) begin
        held_v = 1'b1;
        held_data = mon_data;
      end else begin
        held_v = 1'b0;
      end
      if (mon_busy) busy_cnt++;
      if (mon_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int exp_busy);
    check({tag, "_hs"}, 128'(hs_cnt), 128'(12));
    check({tag, "_busy"}, 128'(busy_cnt), 128'(exp_busy));
    check({tag, "_done"}, 128'(done_cnt), 128'(1));
    check({tag, "_done_at"}, 128'(done_cyc), 128'(last_hs + 1));
    $display("frame %s: hs=%0d busy=%0d done=%0d", tag, hs_cnt, busy_cnt, done_cnt);
  endtask

  initial begin
    logic found;

    // Reset state of both instances
    repeat (2) @(negedge clk);
    check("reset_a", 128'({v_a, busy_a, done_a, gid_a, id_a, col_a, x0_a, y0_a, x1_a, y1_a}), 128'(0));
    check("reset_b", 128'({v_b, busy_b, done_b, gid_b, id_b, col_b, x0_b, y0_b, x1_b, y1_b}), 128'(0));
    rst_n = 1'b1;

    // Plain frame, ready always high
    sel = 1'b0; exp_spacing = 2;
    clear_obs();
    start_a = 1'b1;
    observe(30);
    check_frame("plain", 24);

    // Rasterizer stalls three cycles on line 5
    exp_spacing = 0;
    clear_obs();
    stall_line = 5; stall_left = 3;
    start_a = 1'b1;
    observe(34);
    check_frame("stall", 27);
    stall_line = -1;

    // Abort in FETCH of line 7
    clear_obs();
    start_a = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (busy_a && !v_a && gid_a == 4'd7) found = 1'b1;
    end
    check("abort_reach", 128'(found), 128'(1'b1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", 128'({v_a, busy_a, done_a, gid_a}), 128'(0));
    $display("abort applied in FETCH of line 7");
    clear_obs();
    observe(20);
    check("abort_no_done", 128'(done_cnt), 128'(0));
    check("abort_stays_idle", 128'(busy_cnt), 128'(0));
    exp_spacing = 2;
    clear_obs();
    start_a = 1'b1;
    observe(30);
    check_frame("restart", 24);

    // Start re-pulsed at line 2 and during DONE
    clear_obs();
    repulse = 1'b1;
    start_a = 1'b1;
    observe(45);
    repulse = 1'b0;
    start_a = 1'b0;
    check_frame("repulse", 24);

    // Asynchronous reset during ISSUE of line 4
    start_a = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (v_a && id_a == 4'd4) found = 1'b1;
    end
    check("rst_reach", 128'(found), 128'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", 128'({v_a, busy_a, done_a, gid_a, id_a, col_a, x0_a, y0_a, x1_a, y1_a}), 128'(0));
    $display("async reset applied in ISSUE of line 4");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_idle_after", 128'({v_a, busy_a, done_a}), 128'(0));

    // GEOM_LAT=3 instance with delayed source
    sel = 1'b1; exp_spacing = 4;
    clear_obs();
    start_b = 1'b1;
    observe(60);
    check_frame("lat3", 48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
